// File: rtl/axis_traffic_pkg.sv
// Shared types, payload field offsets and the LFSR step for the AXI-Stream traffic generator.
package axis_traffic_pkg;

  typedef enum logic [1:0] {
    DEST_FIXED  = 2'd0,
    DEST_RR     = 2'd1,
    DEST_RANDOM = 2'd2,
    DEST_RSVD   = 2'd3
  } dest_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam int unsigned FLIT_IDX_LSB = 0;
  localparam int unsigned SEQ_LSB      = 16;
  localparam int unsigned SRC_ID_LSB   = 32;
  localparam int unsigned CHK_LSB      = 48;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/axis_traffic_dest_sel.sv
// Per-packet destination choice (fixed / round-robin / random with round-robin fallback)
// and the round-robin pointer register.
module axis_traffic_dest_sel
  import axis_traffic_pkg::*;
#(
  parameter int TDEST_WIDTH = 4,
  parameter int SRC_ID      = 0,
  parameter int NUM_DESTS   = 10,
  parameter int SKIP_SELF   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  dest_mode_e             mode,
  input  logic [TDEST_WIDTH-1:0] fixed_dest,
  input  logic [TDEST_WIDTH-1:0] rnd,
  input  logic                   load,
  output logic [TDEST_WIDTH-1:0] dest
);

  localparam int unsigned            ND   = NUM_DESTS;
  localparam logic [TDEST_WIDTH-1:0] LAST = TDEST_WIDTH'(NUM_DESTS - 1);
  localparam logic [TDEST_WIDTH-1:0] SELF = TDEST_WIDTH'(SRC_ID);
  localparam bit                     SKIP = (SKIP_SELF != 0);

  logic [TDEST_WIDTH-1:0] ptr;
  logic [TDEST_WIDTH-1:0] ptr_n;
  logic [TDEST_WIDTH-1:0] rr_val;
  logic                   rnd_ok;

  function automatic logic [TDEST_WIDTH-1:0] wrap_inc(input logic [TDEST_WIDTH-1:0] v);
    return (v >= LAST) ? '0 : v + TDEST_WIDTH'(1);
  endfunction

  always_comb begin
    // Skipping self happens in the same cycle, so the pointer can move by two.
    rr_val = (SKIP && ptr == SELF) ? wrap_inc(ptr) : ptr;
    rnd_ok = (32'(rnd) < ND) && !(SKIP && rnd == SELF);
    dest   = fixed_dest;
    ptr_n  = ptr;
    case (mode)
      DEST_RR: begin
        dest  = rr_val;
        ptr_n = wrap_inc(rr_val);
      end
      DEST_RANDOM: begin
        if (rnd_ok) begin
          dest = rnd;
        end else begin
          dest  = rr_val;
          ptr_n = wrap_inc(rr_val);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= ptr_n;
    end
  end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet source with self-describing payloads.
// Optional rate throttling is compiled in with AXIS_TRAFFIC_GEN_THROTTLE_EN.
module axis_traffic_gen
  import axis_traffic_pkg::*;
#(
  parameter int          TDEST_WIDTH = 4,
  parameter int          TDATA_WIDTH = 512,
  parameter int          SRC_ID      = 0,
  parameter int          NUM_DESTS   = 10,
  parameter int          MAX_PKT_LEN = 16,
  parameter int          SKIP_SELF   = 1,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_F00D,
  localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                   clk_usr,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            num_packets,
  input  logic [LEN_W-1:0]       pkt_len,
  input  logic [1:0]             dest_mode,
  input  logic [TDEST_WIDTH-1:0] fixed_dest,
`ifdef AXIS_TRAFFIC_GEN_THROTTLE_EN
  input  logic [7:0]             throttle_thresh,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            flits_sent,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  state_e                 state, state_n;
  logic [15:0]            idx, idx_n;
  logic [15:0]            seq, seq_n;
  logic [15:0]            num_q;
  logic [LEN_W-1:0]       len_q, len_c, sel_len;
  dest_mode_e             mode_q, sel_mode;
  logic [TDEST_WIDTH-1:0] fixed_q, sel_fixed, sel_dest;
  logic [31:0]            lfsr, lfsr_n;
  logic [31:0]            flits_n;
  logic                   tvalid_n, tlast_n;
  logic [TDATA_WIDTH-1:0] tdata_n;
  logic [TDEST_WIDTH-1:0] tdest_n;
  logic                   accept, hs, last_flit, last_pkt, final_hs;
  logic                   load_first, advance, pkt_load, gap_ok;

  function automatic logic [TDATA_WIDTH-1:0] payload(input logic [15:0] i, input logic [15:0] s);
    logic [TDATA_WIDTH-1:0] d;
    d                            = '0;
    d[FLIT_IDX_LSB +: 16]        = i;
    d[SEQ_LSB +: 16]             = s;
    d[SRC_ID_LSB +: TDEST_WIDTH] = TDEST_WIDTH'(SRC_ID);
    d[CHK_LSB +: 16]             = ~i;
    return d;
  endfunction

`ifdef AXIS_TRAFFIC_GEN_THROTTLE_EN
  assign gap_ok = (lfsr[31:24] >= throttle_thresh);
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    if (pkt_len == '0) begin
      len_c = LEN_W'(1);
    end else if (pkt_len > LEN_W'(MAX_PKT_LEN)) begin
      len_c = LEN_W'(MAX_PKT_LEN);
    end else begin
      len_c = pkt_len;
    end
  end

  assign accept    = start && (state != ST_SEND);
  assign hs        = axis_out_tvalid && axis_out_tready;
  assign last_flit = (idx == 16'(len_q - LEN_W'(1)));
  assign last_pkt  = (seq == num_q - 16'd1);
  assign final_hs  = hs && last_flit && last_pkt;
  assign sel_mode  = accept ? dest_mode_e'(dest_mode) : mode_q;
  assign sel_fixed = accept ? fixed_dest : fixed_q;
  assign sel_len   = accept ? len_c : len_q;
  assign busy      = (state == ST_SEND);
  assign done      = (state == ST_DONE);

  axis_traffic_dest_sel #(
    .TDEST_WIDTH (TDEST_WIDTH),
    .SRC_ID      (SRC_ID),
    .NUM_DESTS   (NUM_DESTS),
    .SKIP_SELF   (SKIP_SELF)
  ) u_dest_sel (
    .clk        (clk_usr),
    .rst_n      (rst_n),
    .mode       (sel_mode),
    .fixed_dest (sel_fixed),
    .rnd        (lfsr[TDEST_WIDTH-1:0]),
    .load       (pkt_load),
    .dest       (sel_dest)
  );

  always_comb begin
    state_n    = state;
    tvalid_n   = axis_out_tvalid;
    load_first = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (num_packets == 16'd0) begin
            state_n = ST_DONE;
          end else begin
            state_n    = ST_SEND;
            load_first = 1'b1;
            tvalid_n   = gap_ok;
          end
        end
      end
      ST_SEND: begin
        if (final_hs) begin
          state_n  = ST_DONE;
          tvalid_n = 1'b0;
        end else if (!axis_out_tvalid || hs) begin
          // A gap may only open when no flit is currently being offered.
          tvalid_n = gap_ok;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Bus registers always hold the next flit to offer, even during a throttle gap.
  always_comb begin
    idx_n    = idx;
    seq_n    = seq;
    advance  = load_first || (hs && !final_hs);
    pkt_load = load_first || (hs && !final_hs && last_flit);
    if (load_first) begin
      idx_n = '0;
      seq_n = '0;
    end else if (advance) begin
      if (last_flit) begin
        idx_n = '0;
        seq_n = seq + 16'd1;
      end else begin
        idx_n = idx + 16'd1;
      end
    end
    tlast_n = advance ? (idx_n == 16'(sel_len - LEN_W'(1))) : axis_out_tlast;
    tdata_n = advance ? payload(idx_n, seq_n) : axis_out_tdata;
    tdest_n = pkt_load ? sel_dest : axis_out_tdest;

`ifdef AXIS_TRAFFIC_GEN_THROTTLE_EN
    lfsr_n = lfsr_next(lfsr);
`else
    lfsr_n = lfsr;
`endif
    if (pkt_load && sel_mode == DEST_RANDOM) begin
      lfsr_n = lfsr_next(lfsr_n);
    end

    if (accept) begin
      flits_n = '0;
    end else if (hs && flits_sent != '1) begin
      flits_n = flits_sent + 32'd1;
    end else begin
      flits_n = flits_sent;
    end
  end

  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      seq             <= '0;
      num_q           <= '0;
      len_q           <= LEN_W'(1);
      mode_q          <= DEST_FIXED;
      fixed_q         <= '0;
      lfsr            <= LFSR_SEED;
      flits_sent      <= '0;
      axis_out_tvalid <= 1'b0;
      axis_out_tlast  <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tdest  <= '0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      seq             <= seq_n;
      lfsr            <= lfsr_n;
      flits_sent      <= flits_n;
      axis_out_tvalid <= tvalid_n;
      axis_out_tlast  <= tlast_n;
      axis_out_tdata  <= tdata_n;
      axis_out_tdest  <= tdest_n;
      if (accept) begin
        num_q   <= num_packets;
        len_q   <= len_c;
        mode_q  <= dest_mode_e'(dest_mode);
        fixed_q <= fixed_dest;
      end
    end
  end

endmodule
